div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle iterative divider with its own sequencer for the EX stage of the 5-stage MIPS core.
- Executes DIV/DIVU, holding the pipeline with a stall request while it iterates.
- Presents the quotient and remainder for one cycle so that the HI/LO write path (hilowrite) captures them.
- Uses radix-2 restoring division on operand magnitudes, with a sign fix-up for signed division.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start_i  in  1  level; high while a DIV/DIVU sits in EX and is not annulled.
- signed_i  in  1  1 = DIV (signed), 0 = DIVU; sampled with start_i.
- cancel_i  in  1  pipeline flush/exception; aborts any operation in progress.
- opdata1_i  in  WIDTH  dividend (rs); sampled on acceptance.
- opdata2_i  in  WIDTH  divisor (rt); sampled on acceptance.
- stall_o  out  1  stall request to the hazard unit.
- ready_o  out  1  result valid; one-cycle pulse.
- lo_o  out  WIDTH  quotient; valid when ready_o = 1.
- hi_o  out  WIDTH  remainder; valid when ready_o = 1.

Behaviour:
- Reset: state IDLE; counter, operand and partial registers 0; stall_o = 0, ready_o = 0, lo_o = 0, hi_o = 0. Reset mid-operation discards all work, and no ready_o pulse follows.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On edge E0 with start_i = 1 and cancel_i = 0, latch |opdata1_i|, |opdata2_i| (two's-complement magnitudes when signed_i = 1, raw otherwise).
  - Also latch the quotient sign (sign1 XOR sign2), the remainder sign (sign1), and signed_i.
  - Clear the partial remainder and counter, then go to BUSY.
- BUSY:
  - Each edge performs one iteration: shift {rem, quo} left 1; trial = rem - divisor (WIDTH+1 bits).
  - If trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0.
  - Counter increments. The edge that completes iteration WIDTH (counter = WIDTH-1) moves the state to DONE.
- DONE:
  - ready_o = 1.
  - lo_o = the quotient, negated if the quotient sign is set.
  - hi_o = the remainder, negated if the remainder sign is set. The sign fix-up is combinational from the registers.
  - The next edge returns the state to IDLE. Outputs hold their last values after DONE; only ready_o qualifies them.
- stall_o = (state == IDLE && start_i && !cancel_i) || state == BUSY. It is low in DONE, so EX advances and HI/LO are written that cycle.
- Latency: ready_o is high in the cycle after edge E0 + WIDTH. That is 32 stalled cycles plus the DONE cycle for WIDTH = 32.
- start_i is ignored in BUSY and DONE. The same instruction keeps start_i high through DONE and must not relaunch. A back-to-back divide is accepted only from IDLE.
- cancel_i = 1 in any state gives IDLE on the next edge, with no ready_o pulse. cancel_i has priority over start_i in the same cycle.
- Unsigned divide by zero falls out of the algorithm: lo = all ones, hi = dividend.
- Signed divide by zero applies the normal fix-up, e.g. -5/0 gives lo = 1 and hi = -5.
- Arithmetic: 0x80000000 magnitude is handled as an unsigned 2^31; the result is a quotient of 0x80000000 and a remainder of 0.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined:
  - In IDLE, on acceptance with opdata2_i == 0, go directly to DONE (ready_o in the cycle after E0).
  - Output lo_o = 0xFFFFFFFF and hi_o = raw opdata1_i, for both signed and unsigned.
  - stall_o is high only in the acceptance cycle.
- Undefined: divide by zero takes the full WIDTH iterations, with the results described under Behaviour.

Test Plan:
- DIVU 100/7, start held → stall_o high for 32 cycles; ready_o for exactly 1 cycle with lo = 14, hi = 2; then IDLE, and start_i still high does not relaunch.
- DIV 0xFFFFFFF9 (-7) / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Start DIVU 50/3, then cancel_i at iteration 10 → IDLE next edge, no ready_o, stall_o low; a new DIVU 9/4 then gives lo = 2, hi = 1 after 32 cycles.
- resetn pulsed low asynchronously mid-BUSY (between clock edges) → all outputs 0 immediately; no ready_o after release.
- DIVU 5/0 → lo = 0xFFFFFFFF, hi = 5. Without DIV_ZERO_FAST_EN, ready_o comes after 32 cycles; with it, after 1 cycle.
- start_i and cancel_i high in the same IDLE cycle → no acceptance, stall_o = 0, state remains IDLE.

Source files
------------

// File: rtl/div_seq_if.sv
// Handshake/operand bundle between the EX-stage sequencer and the iterative divider.
interface div_seq_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic             signed_i;
  logic             cancel_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             stall_o;
  logic             ready_o;
  logic [WIDTH-1:0] lo_o;
  logic [WIDTH-1:0] hi_o;

  modport master (output start_i, signed_i, cancel_i, opdata1_i, opdata2_i,
                  input  stall_o, ready_o, lo_o, hi_o);
  modport slave  (input  start_i, signed_i, cancel_i, opdata1_i, opdata2_i,
                  output stall_o, ready_o, lo_o, hi_o);
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring DIV/DIVU sequencer for EX; stalls the pipe while iterating.
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero completes right after acceptance.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic      clk,
    input logic      resetn,
    div_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quo, rem, dvs;
    logic             q_neg, r_neg, sgn_op;

    logic             accept;
    logic             s1, s2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   shifted, trial;

    assign accept  = (state == IDLE) && bus.start_i && !bus.cancel_i;
    assign s1      = bus.signed_i && bus.opdata1_i[WIDTH-1];
    assign s2      = bus.signed_i && bus.opdata2_i[WIDTH-1];
    // 0x80..0 negates to itself, which is exactly its unsigned magnitude
    assign mag1    = s1 ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2    = s2 ? -bus.opdata2_i : bus.opdata2_i;
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            sgn_op <= 1'b0;
        end else if (bus.cancel_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start_i) begin
                    quo    <= mag1;
                    dvs    <= mag2;
                    rem    <= '0;
                    cnt    <= '0;
                    q_neg  <= s1 ^ s2;
                    r_neg  <= s1;
                    sgn_op <= bus.signed_i;
                    state  <= BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (bus.opdata2_i == '0) begin
                        quo   <= '1;
                        rem   <= bus.opdata1_i;
                        q_neg <= 1'b0;
                        r_neg <= 1'b0;
                        state <= DONE;
                    end
`endif
                end
                BUSY: begin
                    // trial MSB set means the subtraction went negative: restore
                    rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall_o = accept || (state == BUSY);
    assign bus.ready_o = (state == DONE);
    assign bus.lo_o    = (sgn_op && q_neg) ? -quo : quo;
    assign bus.hi_o    = (sgn_op && r_neg) ? -rem : rem;
endmodule

// File: tb/tb_div_seq.sv
// Directed + random bench for div_seq with a result scoreboard.
module tb_div_seq;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [63:0] sb[$];

    div_seq_if #(.WIDTH(32)) bus ();
    div_seq #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_of(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        logic [31:0] ma, mb, q, r;
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return {32'hFFFF_FFFF, a};
`endif
        ma = (sgn && a[31]) ? -a : a;
        mb = (sgn && b[31]) ? -b : b;
        if (mb == 0) begin
            q = 32'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        return {q, r};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) return 0;
`endif
        return 32;
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int n, busy, lat;
        logic [63:0] e;
        bus.start_i   = 1'b1;
        bus.signed_i  = sgn;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        sb.push_back(exp_of(a, b, sgn));
        lat = exp_lat(b);
        #1 chk("stall_accept", {31'b0, bus.stall_o}, 1);
        n = 0;
        busy = 0;
        tick;
        while (!bus.ready_o && n < 40) begin
            if (bus.stall_o) busy++;
            n++;
            tick;
        end
        chk("ready_seen", {31'b0, bus.ready_o}, 1);
        chk("latency", n, lat);
        chk("busy_stall", busy, lat);
        chk("stall_done", {31'b0, bus.stall_o}, 0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("lo", bus.lo_o, e[63:32]);
            chk("hi", bus.hi_o, e[31:0]);
        end else begin
            chk("sb_empty", 1, 0);
        end
        // start still high across the DONE edge must not relaunch
        tick;
        bus.start_i = 1'b0;
        #1;
        chk("no_relaunch", {31'b0, bus.stall_o}, 0);
        chk("ready_pulse", {31'b0, bus.ready_o}, 0);
        tick;
    endtask

    initial begin
        int rc;
        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.cancel_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        tick;
        tick;
        chk("rst_stall", {31'b0, bus.stall_o}, 0);
        chk("rst_ready", {31'b0, bus.ready_o}, 0);
        chk("rst_lo", bus.lo_o, 0);
        chk("rst_hi", bus.hi_o, 0);
        resetn = 1'b1;
        tick;

        do_div(32'd100, 32'd7, 1'b0);
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_div(32'd5, 32'd0, 1'b0);
        do_div(32'hFFFF_FFFB, 32'd0, 1'b1);

        // cancel at iteration 10
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd3;
        tick;
        repeat (10) tick;
        bus.cancel_i = 1'b1;
        tick;
        bus.cancel_i = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk("cancel_stall", {31'b0, bus.stall_o}, 0);
        chk("cancel_ready", {31'b0, bus.ready_o}, 0);
        rc = 0;
        repeat (36) begin tick; if (bus.ready_o) rc++; end
        chk("cancel_no_ready", rc, 0);

        // cancel wins over start in IDLE
        bus.start_i = 1'b1; bus.cancel_i = 1'b1;
        #1 chk("sc_stall", {31'b0, bus.stall_o}, 0);
        tick;
        bus.start_i = 1'b0; bus.cancel_i = 1'b0;
        #1 chk("sc_idle", {31'b0, bus.stall_o}, 0);
        tick;

        do_div(32'd9, 32'd4, 1'b0);

        // asynchronous reset mid-BUSY
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
        tick;
        bus.start_i = 1'b0;
        repeat (5) tick;
        #3 resetn = 1'b0;
        #1;
        chk("arst_lo", bus.lo_o, 0);
        chk("arst_hi", bus.hi_o, 0);
        chk("arst_stall", {31'b0, bus.stall_o}, 0);
        chk("arst_ready", {31'b0, bus.ready_o}, 0);
        #1 resetn = 1'b1;
        rc = 0;
        repeat (40) begin tick; if (bus.ready_o) rc++; end
        chk("arst_no_ready", rc, 0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom;
            if (b == 0) b = 1;
            do_div(a, b, (i % 3) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
